// File: rtl/pcie_mwr_tx.sv
// -----------------------------------------------------------------------------
// pcie_mwr_tx : posted Memory Write TLP initiator, 16-bit x1 PCIe transmit (VC0)
//
// A start pulse latches a DMA descriptor. The block waits for posted header and
// data credits, requests the transmit interface and sends a 3DW MWr header. The
// payload is then streamed from a local synchronous-read RAM port.
//
// Ports
//   pcie_clk, rstn        clock, asynchronous active-low reset
//   start                 one-cycle request (sampled only when idle)
//   dma_adr/len/tag       host byte address, payload length (DW), TLP tag
//   ram_base              first local RAM word of the payload
//   bus/dev/func_num      requester ID
//   tx_req/rdy/st/end     transmit handshake and TLP framing
//   tx_data               TLP word (0 outside a TLP)
//   tx_ca_ph/pd/p_recheck posted credit status from the core
//   rd_en/rd_adr/rd_dat   local RAM read port (data one cycle after rd_en)
//   busy/done/err         status: transfer active, completion, rejection
// -----------------------------------------------------------------------------
module pcie_mwr_tx #(
   parameter int MAX_PAYLOAD_DW = 32,
   parameter int RAM_AW         = 9
) (
   input  logic              pcie_clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [31:0]       dma_adr,
   input  logic [9:0]        dma_len,
   input  logic [7:0]        dma_tag,
   input  logic [RAM_AW-1:0] ram_base,
   input  logic [7:0]        bus_num,
   input  logic [4:0]        dev_num,
   input  logic [2:0]        func_num,
   output logic              tx_req,
   input  logic              tx_rdy,
   output logic              tx_st,
   output logic              tx_end,
   output logic [15:0]       tx_data,
   input  logic [8:0]        tx_ca_ph,
   input  logic [12:0]       tx_ca_pd,
   input  logic              tx_ca_p_recheck,
   output logic              rd_en,
   output logic [RAM_AW-1:0] rd_adr,
   input  logic [15:0]       rd_dat,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {S_IDLE, S_CREDIT, S_REQ, S_HDR, S_DATA} state_t;

   localparam logic [10:0]       MAX_LEN = 11'(MAX_PAYLOAD_DW);
   localparam logic [RAM_AW-1:0] ADR_ONE = {{(RAM_AW-1){1'b0}}, 1'b1};

   state_t            r_state;
   logic [31:2]       r_adr;
   logic [9:0]        r_len;
   logic [7:0]        r_tag;
   logic [RAM_AW-1:0] r_base;
   logic [15:0]       r_rid;
   logic [2:0]        r_idx;       // header word currently on tx_data
   logic [10:0]       r_rd_left;   // RAM reads still to issue
   logic [10:0]       r_dcnt;      // payload words left after the current one
   logic              r_tx_req, r_tx_st, r_tx_end, r_rd_en, r_busy, r_done, r_err;
   logic [RAM_AW-1:0] r_rd_adr;
   logic [15:0]       r_tx_data;

   logic        w_len_ok, w_ph_ok, w_pd_ok;
   logic [11:0] w_need_pd;
   logic [10:0] w_words;
   logic [2:0]  w_sel;
   logic [15:0] w_hdr;
   logic        w_unused;

   assign w_len_ok  = (dma_len != 10'd0) && ({1'b0, dma_len} <= MAX_LEN);
   assign w_need_pd = ({2'b00, r_len} + 12'd3) >> 2;
   assign w_ph_ok   = tx_ca_ph[8] | (tx_ca_ph[7:0] != 8'd0);
   assign w_pd_ok   = tx_ca_pd[12] | (tx_ca_pd[11:0] >= w_need_pd);
   assign w_words   = {r_len, 1'b0};
   // DW-aligned addressing: the two byte-offset bits carry no information.
   assign w_unused  = ^dma_adr[1:0];

   // Header word to load next: W0 on grant, otherwise the word after r_idx.
   assign w_sel = (r_state == S_REQ) ? 3'd0 : r_idx + 3'd1;

   always_comb begin
      w_hdr = 16'h0000;
      case (w_sel)
         3'd0: w_hdr = {8'h40, 6'b000000, r_len[9:8]};
         3'd1: w_hdr = {8'h00, r_len[7:0]};
         3'd2: w_hdr = r_rid;
         3'd3: w_hdr = {r_tag, (r_len > 10'd1) ? 4'hF : 4'h0, 4'hF};
         3'd4: w_hdr = r_adr[31:16];
         3'd5: w_hdr = {r_adr[15:2], 2'b00};
         default: w_hdr = 16'h0000;
      endcase
   end

   // NOTE: payload words bypass the output register; the RAM's one-cycle read
   // latency already lines rd_dat up with the word slot after W5.
   assign tx_data = (r_state == S_DATA) ? rd_dat : r_tx_data;

   assign tx_req = r_tx_req;
   assign tx_st  = r_tx_st;
   assign tx_end = r_tx_end;
   assign rd_en  = r_rd_en;
   assign rd_adr = r_rd_adr;
   assign busy   = r_busy;
   assign done   = r_done;
   assign err    = r_err;

   // NOTE: all state uses non-blocking assignments so every register sees the
   // pre-edge value of every other register, independent of statement order.
   always_ff @(posedge pcie_clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_adr     <= '0;
         r_len     <= '0;
         r_tag     <= '0;
         r_base    <= '0;
         r_rid     <= '0;
         r_idx     <= '0;
         r_rd_left <= '0;
         r_dcnt    <= '0;
         r_tx_req  <= 1'b0;
         r_tx_st   <= 1'b0;
         r_tx_end  <= 1'b0;
         r_tx_data <= '0;
         r_rd_en   <= 1'b0;
         r_rd_adr  <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;

         // Read issue runs on its own once primed from the header phase.
         if (r_rd_left != 11'd0) begin
            r_rd_en   <= 1'b1;
            r_rd_adr  <= r_rd_adr + ADR_ONE;
            r_rd_left <= r_rd_left - 11'd1;
         end else begin
            r_rd_en <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_len_ok) begin
                     r_adr   <= dma_adr[31:2];
                     r_len   <= dma_len;
                     r_tag   <= dma_tag;
                     r_base  <= ram_base;
                     r_rid   <= {bus_num, dev_num, func_num};
                     r_busy  <= 1'b1;
                     r_state <= S_CREDIT;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_CREDIT: begin
               // Credit values are unsettled during a recheck cycle.
               if (!tx_ca_p_recheck && w_ph_ok && w_pd_ok) begin
                  r_tx_req <= 1'b1;
                  r_state  <= S_REQ;
               end
            end
            S_REQ: begin
               if (tx_rdy) begin
                  r_tx_req  <= 1'b0;
                  r_tx_st   <= 1'b1;
                  r_tx_data <= w_hdr;
                  r_idx     <= 3'd0;
                  r_state   <= S_HDR;
               end
            end
            S_HDR: begin
               r_tx_st <= 1'b0;
               r_idx   <= r_idx + 3'd1;
               if (r_idx == 3'd5) begin
                  r_tx_data <= 16'h0000;
                  r_dcnt    <= w_words - 11'd1;
                  r_state   <= S_DATA;
               end else begin
                  r_tx_data <= w_hdr;
               end
               // First read goes out alongside W5 so its data lands on data word 0.
               if (r_idx == 3'd4) begin
                  r_rd_en   <= 1'b1;
                  r_rd_adr  <= r_base;
                  r_rd_left <= w_words - 11'd1;
               end
            end
            S_DATA: begin
               if (r_tx_end) begin
                  r_tx_end <= 1'b0;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
               end else begin
                  if (r_dcnt == 11'd1) r_tx_end <= 1'b1;
                  r_dcnt <= r_dcnt - 11'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/pcie_mwr_tx.md
Name: pcie_mwr_tx

Overview:
Posted-write TLP initiator for the 16-bit x1 PCIe transaction interface (VC0 transmit side). On a start pulse it checks posted credits and builds a 3DW Memory Write header. It then streams the payload from a local synchronous-read RAM port and frames the TLP with tx_req/tx_st/tx_end. This is the outbound (bus-master) counterpart of the target-side TLP receiver that serves BAR accesses into the same RAM.

Parameters:
MAX_PAYLOAD_DW, 32, largest accepted dma_len in DW (128 bytes)
RAM_AW, 9, local RAM word-address width (16-bit words)

Ports:
pcie_clk  in  1  125 MHz transaction-layer clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle request pulse; ignored while busy
dma_adr  in  32  host byte address; bits [1:0] ignored
dma_len  in  10  payload length in DW
dma_tag  in  8  TLP tag
ram_base  in  RAM_AW  first RAM word of the payload
bus_num  in  8  requester bus number
dev_num  in  5  requester device number
func_num  in  3  requester function number
tx_req  out  1  transmit request to core
tx_rdy  in  1  core grant
tx_st  out  1  first TLP word strobe
tx_end  out  1  last TLP word strobe
tx_data  out  16  TLP word
tx_ca_ph  in  9  posted header credits; bit 8 = infinite
tx_ca_pd  in  13  posted data credits (4 DW units); bit 12 = infinite
tx_ca_p_recheck  in  1  credit values updated, re-evaluate
rd_en  out  1  RAM read enable
rd_adr  out  RAM_AW  RAM word address
rd_dat  in  16  RAM data, valid one cycle after rd_en
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle rejection pulse

Behaviour:
- Reset: all outputs 0, state IDLE, rd_adr 0.
- start is sampled only in IDLE. dma_adr, dma_len, dma_tag, ram_base and the requester ID are latched on start.
- Rejection: dma_len==0 or dma_len>MAX_PAYLOAD_DW -> err pulses the next cycle, state stays IDLE, busy never rises.
- States: IDLE -> CREDIT -> REQ -> HDR -> DATA -> IDLE.
- busy is 1 from the cycle after an accepted start until the cycle done pulses.
- CREDIT: need_pd = ceil(len/4). Advance when (ph[8] | ph[7:0]>=1) and (pd[12] | pd[11:0]>=need_pd).
  - Evaluate every cycle. A tx_ca_p_recheck cycle is not used for the decision; it is re-evaluated the following cycle.
  - Wait indefinitely otherwise.
- REQ: tx_req=1 and held until tx_rdy is sampled high.
  - The cycle after tx_rdy: tx_req=0, tx_st=1, header word 0 driven, state HDR.
  - The core does not throttle once tx_st is given; words are contiguous, one per cycle.
- HDR: 6 words, high half of each DW first.
  - W0 = {8'h40, 6'b0, len[9:8]}
  - W1 = len[7:0] in the low byte, TC/TD/EP/attr 0
  - W2 = {bus,dev,func}
  - W3 = {tag, lastBE, 4'hF}, where lastBE = 4'hF if len>1 else 4'h0
  - W4 = adr[31:16]
  - W5 = {adr[15:2], 2'b00}
- RAM reads: rd_en=1 with rd_adr=ram_base during W5. Each subsequent cycle issues rd_adr+1 until 2*len reads have been issued.
  - rd_adr wraps modulo 2^RAM_AW.
- DATA: tx_data = rd_dat, 2*len words.
  - tx_end=1 on the final data word.
  - done pulses the cycle after tx_end; state returns to IDLE.
- Latency: start -> tx_req = 2 cycles when credits are already available.
  - TLP length = 6 + 2*len cycles from tx_st through tx_end.
- start during busy: ignored, no err.
- rstn asserted mid-TLP: outputs clear immediately and asynchronously. No tx_end is emitted; the core's own reset discards the partial TLP.
- tx_data = 0 whenever not inside a TLP.

Test Plan:
- Infinite credits (ph=9'h100, pd=13'h1000), start with adr=32'h1000_0040, len=1, tag=8'h05, bus/dev/func=01/00/0, tx_rdy one cycle after tx_req -> 8 words: 4000 0001 0100 050F 1000 0040 then RAM[0], RAM[1]; tx_st on word 1, tx_end on word 8; done one cycle later.
- len=32, ram_base=9'h1FC -> rd_adr sequence 1FC..1FF, 000..03B (64 reads, wrap verified); W3 low byte = 8'hFF; 70-cycle TLP.
- ph=1, pd=3, len=16 (need 4) -> holds in CREDIT with tx_req=0; set pd=4 with recheck pulse -> tx_req rises 2 cycles later.
- len=0 and len=33 -> err pulse, busy stays 0, no tx_req.
- tx_rdy withheld 10 cycles -> tx_req held steady; second start during the TLP -> ignored.
- rstn low during DATA word 3 -> all outputs 0 immediately; after release, a fresh start produces a correct complete TLP.
